// File: rtl/seg7_scan.sv
// Four-digit multiplexed seven-segment driver for the up/down counter.
// Shows the value as 00-15 with leading-zero blanking, a U/d direction glyph, and blinks while paused.
module seg7_scan #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLINK_FRAMES = 25,
  parameter bit ACTIVE_LOW   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] value,
  input  logic       dir,
  input  logic       paused,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BCNT_MAX = BW'(BLINK_FRAMES);

  localparam logic [6:0] SEG_U = 7'h3E;
  localparam logic [6:0] SEG_D = 7'h5E;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [3:0]    value_q, value_d;
  logic          dir_q, dir_d;
  logic          paused_q, paused_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic          ph_q, ph_d;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          tick_q, tick_d;

  logic          slot_end, wrap;
  logic [3:0]    units;
  logic [3:0]    an_hi;
  logic [6:0]    seg_hi;
  logic          dp_hi;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  always_comb begin
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    value_d  = value_q;
    dir_d    = dir_q;
    paused_d = paused_q;
    bcnt_d   = bcnt_q;
    ph_d     = ph_q;
    tick_d   = 1'b0;

    slot_end = (cnt_q == CNT_MAX);
    wrap     = slot_end && (idx_q == 2'd3);

    if (slot_end) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end

    // Blink state follows the freshly captured paused flag, so resume is visible next frame.
    if (wrap) begin
      value_d  = value;
      dir_d    = dir;
      paused_d = paused;
      tick_d   = 1'b1;
      if (!paused) begin
        bcnt_d = '0;
        ph_d   = 1'b0;
      end else if (bcnt_q == BCNT_MAX) begin
        bcnt_d = BW'(1);
        ph_d   = ~ph_q;
      end else begin
        bcnt_d = bcnt_q + BW'(1);
      end
    end

    // Decode from next-state values so the registered outputs match the captured data.
    units = (value_d >= 4'd10) ? (value_d - 4'd10) : value_d;
    an_hi = 4'b0001 << idx_d;
    dp_hi = (idx_d == 2'd0) && paused_d;
    case (idx_d)
      2'd0:    seg_hi = ph_d ? 7'h00 : dec7(units);
      2'd1:    seg_hi = (ph_d || value_d < 4'd10) ? 7'h00 : dec7(4'd1);
      2'd2:    seg_hi = 7'h00;
      default: seg_hi = dir_d ? SEG_U : SEG_D;
    endcase

    an_d  = ACTIVE_LOW ? ~an_hi  : an_hi;
    seg_d = ACTIVE_LOW ? ~seg_hi : seg_hi;
    dp_d  = ACTIVE_LOW ? ~dp_hi  : dp_hi;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= CNT_MAX;
      idx_q    <= 2'd3;
      value_q  <= '0;
      dir_q    <= 1'b0;
      paused_q <= 1'b0;
      bcnt_q   <= '0;
      ph_q     <= 1'b0;
      an_q     <= ACTIVE_LOW ? 4'hF : 4'h0;
      seg_q    <= ACTIVE_LOW ? 7'h7F : 7'h00;
      dp_q     <= ACTIVE_LOW ? 1'b1 : 1'b0;
      tick_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      value_q  <= value_d;
      dir_q    <= dir_d;
      paused_q <= paused_d;
      bcnt_q   <= bcnt_d;
      ph_q     <= ph_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      tick_q   <= tick_d;
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign dp         = dp_q;
  assign frame_tick = tick_q;

endmodule
